// File: rtl/mesh_match_responder_if.sv
// Bundle of the router-side, match-PE-side and status signals of the mesh match responder.
// slave is the responder's view; master is the view of the surrounding router/PE/environment.
interface mesh_match_responder_if #(
  parameter int unsigned X_SIZE          = 8,
  parameter int unsigned Y_SIZE          = 8,
  parameter int unsigned ADDR_WIDTH      = 24,
  parameter int unsigned TAG_WIDTH       = 4,
  parameter int unsigned MATCH_LEN_WIDTH = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
);
  localparam int unsigned XW        = $clog2(X_SIZE);
  localparam int unsigned YW        = $clog2(Y_SIZE);
  localparam int unsigned JOB_IDX_W = XW + YW - 1;
  localparam int unsigned W         = 2 * ADDR_WIDTH + TAG_WIDTH + JOB_IDX_W;
  localparam int unsigned CW        = $clog2(MAX_OUTSTANDING) + 1;

  logic                       i_net_valid;
  logic [XW-1:0]              i_net_dst_x;
  logic [YW-1:0]              i_net_dst_y;
  logic [W-1:0]               i_net_payload;
  logic                       i_net_ready;

  logic                       o_req_valid;
  logic [ADDR_WIDTH-1:0]      o_req_head_addr;
  logic [ADDR_WIDTH-1:0]      o_req_history_addr;
  logic                       o_req_ready;

  logic                       i_resp_valid;
  logic [MATCH_LEN_WIDTH-1:0] i_resp_match_len;
  logic                       i_resp_ready;

  logic                       o_net_valid;
  logic [XW-1:0]              o_net_dst_x;
  logic [YW-1:0]              o_net_dst_y;
  logic [W-1:0]               o_net_payload;
  logic                       o_net_ready;

  logic [CW-1:0]              o_outstanding;
  logic                       o_err_non_request;

  modport slave (
    input  i_net_valid, i_net_dst_x, i_net_dst_y, i_net_payload,
    output i_net_ready,
    output o_req_valid, o_req_head_addr, o_req_history_addr,
    input  o_req_ready,
    input  i_resp_valid, i_resp_match_len,
    output i_resp_ready,
    output o_net_valid, o_net_dst_x, o_net_dst_y, o_net_payload,
    input  o_net_ready,
    output o_outstanding, o_err_non_request
  );

  modport master (
    output i_net_valid, i_net_dst_x, i_net_dst_y, i_net_payload,
    input  i_net_ready,
    input  o_req_valid, o_req_head_addr, o_req_history_addr,
    output o_req_ready,
    output i_resp_valid, i_resp_match_len,
    input  i_resp_ready,
    input  o_net_valid, o_net_dst_x, o_net_dst_y, o_net_payload,
    output o_net_ready,
    input  o_outstanding, o_err_non_request
  );
endinterface

// File: rtl/mesh_match_responder.sv
// Mesh network interface for a shared match PE: forwards match requests to the PE and turns
// in-order results plus saved {tag, job_idx} context into response packets for the job PE.
module mesh_match_responder #(
  parameter int unsigned X_SIZE          = 8,
  parameter int unsigned Y_SIZE          = 8,
  parameter int unsigned ADDR_WIDTH      = 24,
  parameter int unsigned TAG_WIDTH       = 4,
  parameter int unsigned MATCH_LEN_WIDTH = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic                   clk,
  input logic                   rst,
  mesh_match_responder_if.slave bus
);
  localparam int unsigned XW        = $clog2(X_SIZE);
  localparam int unsigned YW        = $clog2(Y_SIZE);
  localparam int unsigned JOB_IDX_W = XW + YW - 1;
  localparam int unsigned W         = 2 * ADDR_WIDTH + TAG_WIDTH + JOB_IDX_W;
  localparam int unsigned PW        = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned CTXW      = TAG_WIDTH + JOB_IDX_W;

  logic [ADDR_WIDTH-1:0] in_head, in_hist;
  logic [TAG_WIDTH-1:0]  in_tag;
  logic [JOB_IDX_W-1:0]  in_job;
  assign {in_head, in_hist, in_tag, in_job} = bus.i_net_payload;

  logic                  req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0] head_q, head_d, hist_q, hist_d;

  logic [CTXW-1:0]       ctx_mem_q [MAX_OUTSTANDING];
  // Pointers carry one extra bit so full and empty differ when the low bits match.
  logic [PW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  ctx_empty;
  logic [TAG_WIDTH-1:0]  ctx_tag;
  logic [JOB_IDX_W-1:0]  ctx_job;

  logic                  net_valid_q, net_valid_d;
  logic [XW-1:0]         dst_x_q, dst_x_d;
  logic [YW-1:0]         dst_y_q, dst_y_d;
  logic [W-1:0]          payload_q, payload_d;

  logic [CW-1:0]         ctx_count_q, ctx_count_d;
  logic                  err_q, err_d;

  logic net_ready, net_fire, is_req, push;
  logic resp_ready, resp_fire, out_fire;

  assign ctx_empty          = (wr_ptr_q == rd_ptr_q);
  assign {ctx_tag, ctx_job} = ctx_mem_q[rd_ptr_q[PW-1:0]];

  assign is_req     = bus.i_net_dst_y[0];
  assign net_ready  = !rst && (!req_valid_q || bus.o_req_ready)
                      && (ctx_count_q < CW'(MAX_OUTSTANDING));
  assign net_fire   = bus.i_net_valid && net_ready;
  assign push       = net_fire && is_req;
  assign resp_ready = !ctx_empty && (!net_valid_q || bus.o_net_ready);
  assign resp_fire  = bus.i_resp_valid && resp_ready;
  assign out_fire   = net_valid_q && bus.o_net_ready;

  always_comb begin
    req_valid_d = req_valid_q;
    head_d      = head_q;
    hist_d      = hist_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    net_valid_d = net_valid_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    payload_d   = payload_q;
    ctx_count_d = ctx_count_q;
    err_d       = err_q | (net_fire & ~is_req);

    if (req_valid_q && bus.o_req_ready) req_valid_d = 1'b0;
    if (push) begin
      req_valid_d = 1'b1;
      head_d      = in_head;
      hist_d      = in_hist;
      wr_ptr_d    = wr_ptr_q + 1'b1;
    end

    if (out_fire) net_valid_d = 1'b0;
    if (resp_fire) begin
      net_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
      dst_x_d     = ctx_job[XW-1:0];
      // Bit 0 clear marks the packet as a response.
      dst_y_d     = {ctx_job[JOB_IDX_W-1:XW], 1'b0};
      payload_d   = W'({bus.i_resp_match_len, ctx_tag});
    end

    unique case ({push, out_fire})
      2'b10:   ctx_count_d = ctx_count_q + 1'b1;
      2'b01:   ctx_count_d = ctx_count_q - 1'b1;
      default: ctx_count_d = ctx_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      head_q      <= '0;
      hist_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      net_valid_q <= 1'b0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      payload_q   <= '0;
      ctx_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      head_q      <= head_d;
      hist_q      <= hist_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      net_valid_q <= net_valid_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      payload_q   <= payload_d;
      ctx_count_q <= ctx_count_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) ctx_mem_q[wr_ptr_q[PW-1:0]] <= {in_tag, in_job};
  end

  assign bus.i_net_ready        = net_ready;
  assign bus.o_req_valid        = req_valid_q;
  assign bus.o_req_head_addr    = head_q;
  assign bus.o_req_history_addr = hist_q;
  assign bus.i_resp_ready       = resp_ready;
  assign bus.o_net_valid        = net_valid_q;
  assign bus.o_net_dst_x        = dst_x_q;
  assign bus.o_net_dst_y        = dst_y_q;
  assign bus.o_net_payload      = payload_q;
  assign bus.o_outstanding      = ctx_count_q;
  assign bus.o_err_non_request  = err_q;
endmodule

// File: tb/tb_mesh_match_responder.sv
// Scoreboard bench for mesh_match_responder: requests push expected PE requests and responses
// into queues; a negedge monitor pops and compares on every completed handshake.
module tb_mesh_match_responder;
  localparam int unsigned XW = 3;
  localparam int unsigned YW = 3;
  localparam int unsigned AW = 24;
  localparam int unsigned TW = 4;
  localparam int unsigned JW = 5;
  localparam int unsigned W  = 57;

  typedef struct packed {
    logic [AW-1:0] head;
    logic [AW-1:0] hist;
  } req_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [W-1:0]  pl;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mesh_match_responder_if bus ();

  mesh_match_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int max_out  = 0;
  logic track  = 1'b0;
  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t mon_req;
  rsp_t mon_rsp;

  // Match-PE model: manual drive, or a same-cycle combinational responder for streaming.
  logic       pe_comb      = 1'b0;
  logic       req_rdy_drv  = 1'b0;
  logic       resp_vld_drv = 1'b0;
  logic [7:0] resp_len_drv = 8'd0;
  assign bus.o_req_ready      = pe_comb ? bus.i_resp_ready : req_rdy_drv;
  assign bus.i_resp_valid     = pe_comb ? bus.o_req_valid : resp_vld_drv;
  assign bus.i_resp_match_len = pe_comb ? bus.o_req_head_addr[7:0] : resp_len_drv;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic [JW-1:0] job, input logic [TW-1:0] tag,
                                  input logic [7:0] len);
    rsp_t r;
    r.x  = job[XW-1:0];
    r.y  = {job[JW-1:XW], 1'b0};
    r.pl = W'({len, tag});
    return r;
  endfunction

  always @(negedge clk) begin
    if (track && int'(bus.o_outstanding) > max_out) max_out = int'(bus.o_outstanding);
    if (!rst) begin
      if (bus.o_req_valid && bus.o_req_ready) begin
        if (req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_o_req: got head 0x%0h, expected none", bus.o_req_head_addr);
        end else begin
          mon_req = req_q.pop_front();
          check("o_req", 64'({bus.o_req_head_addr, bus.o_req_history_addr}), 64'(mon_req));
        end
      end
      if (bus.o_net_valid && bus.o_net_ready) begin
        if (rsp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_o_net: got payload 0x%0h, expected none", bus.o_net_payload);
        end else begin
          mon_rsp = rsp_q.pop_front();
          check("o_net", 64'({bus.o_net_dst_x, bus.o_net_dst_y, bus.o_net_payload}),
                64'(mon_rsp));
        end
      end
    end
  end

  // Called just after a posedge; returns just after the edge on which the packet transferred.
  task automatic net_send(input logic [XW-1:0] x, input logic [YW-1:0] y,
                          input logic [AW-1:0] head, input logic [AW-1:0] hist,
                          input logic [TW-1:0] tag, input logic [JW-1:0] job,
                          input logic [7:0] len);
    int  k  = 0;
    bit  ok = 1'b0;
    bus.i_net_valid   = 1'b1;
    bus.i_net_dst_x   = x;
    bus.i_net_dst_y   = y;
    bus.i_net_payload = {head, hist, tag, job};
    while (k < 50 && !ok) begin
      @(negedge clk);
      ok = bus.i_net_ready;
      k++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL net_send_timeout: got i_net_ready 0, expected 1 within 50 cycles");
      bus.i_net_valid = 1'b0;
      return;
    end
    if (y[0]) begin
      req_q.push_back('{head: head, hist: hist});
      rsp_q.push_back(mk_rsp(job, tag, len));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pe_result(input logic [7:0] len);
    int k  = 0;
    bit ok = 1'b0;
    resp_vld_drv = 1'b1;
    resp_len_drv = len;
    while (k < 50 && !ok) begin
      @(negedge clk);
      ok = bus.i_resp_ready;
      k++;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL pe_result_timeout: got i_resp_ready 0, expected 1 within 50 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
    resp_vld_drv = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (k < 200 && (req_q.size() != 0 || rsp_q.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(req_q.size() + rsp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst                 = 1'b1;
    bus.i_net_valid     = 1'b0;
    bus.i_net_dst_x     = '0;
    bus.i_net_dst_y     = '0;
    bus.i_net_payload   = '0;
    bus.o_net_ready     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_i_net_ready", 64'(bus.i_net_ready), 64'd0);
    check("rst_o_req_valid", 64'(bus.o_req_valid), 64'd0);
    check("rst_o_net_valid", 64'(bus.o_net_valid), 64'd0);
    check("rst_outstanding", 64'(bus.o_outstanding), 64'd0);
    check("rst_err", 64'(bus.o_err_non_request), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request
    req_rdy_drv     = 1'b1;
    bus.o_net_ready = 1'b1;
    net_send(3'd3, 3'd5, 24'h000100, 24'h000040, 4'd2, 5'd13, 8'd17);
    bus.i_net_valid = 1'b0;
    check("single_req_valid", 64'(bus.o_req_valid), 64'd1);
    check("single_req_head", 64'(bus.o_req_head_addr), 64'h100);
    check("single_req_hist", 64'(bus.o_req_history_addr), 64'h40);
    pe_result(8'd17);
    check("single_net_valid", 64'(bus.o_net_valid), 64'd1);
    check("single_dst_x", 64'(bus.o_net_dst_x), 64'd5);
    check("single_dst_y", 64'(bus.o_net_dst_y), 64'd2);
    check("single_payload_lo", 64'(bus.o_net_payload[11:0]), 64'h112);
    cycles(1);
    check("single_outstanding", 64'(bus.o_outstanding), 64'd0);

    // Five back-to-back requests with the PE holding its results
    for (int i = 0; i < 4; i++)
      net_send(3'd0, 3'd1, 24'h001000 + 24'(i), 24'h002000 + 24'(i), TW'(i), JW'(i + 8),
               8'h30 + 8'(i));
    bus.i_net_valid   = 1'b1;
    bus.i_net_dst_y   = 3'd1;
    bus.i_net_payload = {24'h001004, 24'h002004, 4'd4, 5'd12};
    @(negedge clk);
    check("five_ready_low", 64'(bus.i_net_ready), 64'd0);
    check("five_outstanding", 64'(bus.o_outstanding), 64'd4);
    @(posedge clk);
    #1;
    pe_result(8'h30);
    net_send(3'd0, 3'd1, 24'h001004, 24'h002004, 4'd4, 5'd12, 8'h34);
    bus.i_net_valid = 1'b0;
    for (int i = 1; i < 5; i++) pe_result(8'h30 + 8'(i));
    wait_drain("five_drain");
    check("five_outstanding_end", 64'(bus.o_outstanding), 64'd0);

    // Output back-pressure
    bus.o_net_ready = 1'b0;
    net_send(3'd0, 3'd1, 24'h003000, 24'h000111, 4'd0, 5'd9, 8'h55);
    net_send(3'd0, 3'd1, 24'h003001, 24'h000222, 4'd1, 5'd10, 8'h66);
    bus.i_net_valid = 1'b0;
    pe_result(8'h55);
    resp_vld_drv = 1'b1;
    resp_len_drv = 8'h66;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_resp_ready_low", 64'(bus.i_resp_ready), 64'd0);
      check("bp_net_valid_held", 64'(bus.o_net_valid), 64'd1);
      check("bp_payload_held", 64'(bus.o_net_payload), 64'h550);
    end
    @(posedge clk);
    #1;
    bus.o_net_ready = 1'b1;
    pe_result(8'h66);
    wait_drain("bp_drain");

    // Non-request packet
    net_send(3'd2, 3'd4, 24'h000abc, 24'h000def, 4'd3, 5'd7, 8'd0);
    bus.i_net_valid = 1'b0;
    check("nonreq_err", 64'(bus.o_err_non_request), 64'd1);
    check("nonreq_no_req", 64'(bus.o_req_valid), 64'd0);
    check("nonreq_outstanding", 64'(bus.o_outstanding), 64'd0);
    cycles(3);
    check("nonreq_err_sticky", 64'(bus.o_err_non_request), 64'd1);
    check("nonreq_no_req_later", 64'(bus.o_req_valid), 64'd0);

    // Streaming across FIFO pointer wrap
    pe_comb = 1'b1;
    max_out = 0;
    track   = 1'b1;
    c0      = cyc;
    for (int i = 0; i < 32; i++)
      net_send(3'd0, 3'd1, 24'h040000 + 24'(i * 7 + 1), 24'h050000 + 24'(i), TW'(i),
               JW'((i * 3) % 32), 8'(i * 7 + 1));
    check("stream_cycles", 64'(cyc - c0), 64'd32);
    bus.i_net_valid = 1'b0;
    wait_drain("stream_drain");
    track   = 1'b0;
    pe_comb = 1'b0;
    check("stream_max_outstanding", 64'(max_out), 64'd2);

    // Reset mid-operation
    bus.o_net_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      net_send(3'd0, 3'd1, 24'h006000 + 24'(i), 24'h007000 + 24'(i), TW'(i + 5), JW'(i + 1),
               8'h11 + 8'(i));
    bus.i_net_valid = 1'b0;
    pe_result(8'h11);
    check("mid_net_valid", 64'(bus.o_net_valid), 64'd1);
    check("mid_outstanding", 64'(bus.o_outstanding), 64'd3);
    rst = 1'b1;
    req_q.delete();
    rsp_q.delete();
    @(negedge clk);
    check("mid_rst_ready_low", 64'(bus.i_net_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_req_valid", 64'(bus.o_req_valid), 64'd0);
    check("post_rst_net_valid", 64'(bus.o_net_valid), 64'd0);
    check("post_rst_outstanding", 64'(bus.o_outstanding), 64'd0);
    check("post_rst_err", 64'(bus.o_err_non_request), 64'd0);
    check("post_rst_resp_ready", 64'(bus.i_resp_ready), 64'd0);
    bus.o_net_ready = 1'b1;
    net_send(3'd1, 3'd3, 24'h007777, 24'h008888, 4'd9, 5'd20, 8'h42);
    bus.i_net_valid = 1'b0;
    pe_result(8'h42);
    wait_drain("post_rst_drain");
    check("post_rst_outstanding_end", 64'(bus.o_outstanding), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
